// File: rtl/sim_stop_pkg.sv
// Shared types and helpers for the end-of-simulation sequencer and its UART monitor.
package sim_stop_pkg;

  localparam int SEQ_STATE_W = 3;

  typedef enum logic [SEQ_STATE_W-1:0] {
    IDLE     = 3'd0,
    ARMED    = 3'd1,
    DRAIN    = 3'd2,
    WAIT_REC = 3'd3,
    GUARD    = 3'd4,
    STOP     = 3'd5
  } seq_state_e;

  // Width needed for a saturating counter that must be able to hold max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic logic [15:0] lowest_one(input logic [15:0] v);
    return v & (~v + 16'd1);
  endfunction

endpackage

// File: rtl/sim_stop_sequencer_if.sv
// Signal bundle between the simulation manager and the stop sequencer.
// RVX_SIM_STOP_WATCHDOG_EN adds the watchdog_fired indication.
interface sim_stop_sequencer_if
  import sim_stop_pkg::*;
#(
  parameter int NUM_SRC = 4
);
  logic [NUM_SRC-1:0]     stop_req;
  logic                   uart_tx;
  logic                   record_enable;
  logic                   sim_stop;
  logic [NUM_SRC-1:0]     stop_cause;
  logic                   drain_timeout;
  logic [SEQ_STATE_W-1:0] seq_state;
`ifdef RVX_SIM_STOP_WATCHDOG_EN
  logic                   watchdog_fired;

  modport master (
    output stop_req, uart_tx, record_enable,
    input  sim_stop, stop_cause, drain_timeout, seq_state, watchdog_fired
  );
  modport slave (
    input  stop_req, uart_tx, record_enable,
    output sim_stop, stop_cause, drain_timeout, seq_state, watchdog_fired
  );
`else
  modport master (
    output stop_req, uart_tx, record_enable,
    input  sim_stop, stop_cause, drain_timeout, seq_state
  );
  modport slave (
    input  stop_req, uart_tx, record_enable,
    output sim_stop, stop_cause, drain_timeout, seq_state
  );
`endif
endinterface

// File: rtl/uart_idle_detector.sv
// Counts consecutive high samples of a UART line; done when THRESHOLD is reached this cycle.
module uart_idle_detector
  import sim_stop_pkg::*;
#(
  parameter int THRESHOLD = 320
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic line,
  output logic done
);
  localparam int              CNT_W = cnt_width(THRESHOLD);
  localparam logic [CNT_W-1:0] THR  = CNT_W'(THRESHOLD);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;

  // A low sample restarts the count even on the cycle it would have completed.
  always_comb begin
    cnt_nxt = cnt_q;
    if (!line)
      cnt_nxt = '0;
    else if (cnt_q != THR)
      cnt_nxt = cnt_q + 1'b1;
  end

  assign done = enable && line && (cnt_nxt == THR);

  always_ff @(posedge clk) begin
    if (rst || clear)
      cnt_q <= '0;
    else if (enable)
      cnt_q <= cnt_nxt;
  end

endmodule

// File: rtl/sim_stop_sequencer.sv
// End-of-simulation controller: arbitrates stop requests, waits out min run time,
// UART drain and recording close. RVX_SIM_STOP_WATCHDOG_EN adds a global watchdog.
//
// state    | meaning
// IDLE     | no request latched yet
// ARMED    | cause latched, waiting for minimum run time
// DRAIN    | waiting for the UART line to stay idle (or timeout)
// WAIT_REC | waiting for waveform recording to close
// GUARD    | one settling cycle
// STOP     | sim_stop asserted, terminal until reset
module sim_stop_sequencer
  import sim_stop_pkg::*;
#(
  parameter int NUM_SRC         = 4,
  parameter int MIN_RUN_CYCLES  = 1000,
  parameter int BIT_CYCLES      = 16,
  parameter int DRAIN_BITS      = 20,
  parameter int DRAIN_TIMEOUT   = 100000
`ifdef RVX_SIM_STOP_WATCHDOG_EN
  ,
  parameter int WATCHDOG_CYCLES = 10000000
`endif
) (
  input logic                  clk,
  input logic                  rst,
  sim_stop_sequencer_if.slave  bus
);
  localparam int               RUN_W    = cnt_width(MIN_RUN_CYCLES);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MIN_RUN_CYCLES);
  localparam int               TO_W     = cnt_width(DRAIN_TIMEOUT);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(DRAIN_TIMEOUT);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(DRAIN_TIMEOUT - 1);

  seq_state_e         state_q, state_nxt;
  logic [NUM_SRC-1:0] pending_q;
  logic [NUM_SRC-1:0] cause_q, cause_nxt;
  logic               dto_q, dto_nxt;
  logic [RUN_W-1:0]   run_cnt_q;
  logic [TO_W-1:0]    to_cnt_q;
  logic               run_ok;
  logic               timeout_hit;
  logic               idle_done;
  logic [15:0]        req_ext;
  logic [15:0]        req_sel;

  assign run_ok      = (run_cnt_q == RUN_MAX);
  assign timeout_hit = (state_q == DRAIN) && (to_cnt_q == TO_LAST);

  uart_idle_detector #(
    .THRESHOLD (DRAIN_BITS * BIT_CYCLES)
  ) u_idle (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q != DRAIN),
    .enable (state_q == DRAIN),
    .line   (bus.uart_tx),
    .done   (idle_done)
  );

`ifdef RVX_SIM_STOP_WATCHDOG_EN
  localparam int              WD_W   = cnt_width(WATCHDOG_CYCLES);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WATCHDOG_CYCLES);

  logic [WD_W-1:0] wd_cnt_q;
  logic            wd_fired_q, wd_fired_nxt;
  logic            wd_hit;

  assign wd_hit = (wd_cnt_q == WD_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q   <= '0;
      wd_fired_q <= 1'b0;
    end else begin
      if (!wd_hit)
        wd_cnt_q <= wd_cnt_q + 1'b1;
      wd_fired_q <= wd_fired_nxt;
    end
  end

  assign bus.watchdog_fired = wd_fired_q;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    cause_nxt = cause_q;
    dto_nxt   = dto_q;
    req_ext   = '0;
    req_ext[NUM_SRC-1:0] = pending_q | bus.stop_req;
    req_sel   = lowest_one(req_ext);
`ifdef RVX_SIM_STOP_WATCHDOG_EN
    wd_fired_nxt = wd_fired_q;
`endif
    case (state_q)
      IDLE: begin
        if (pending_q != '0) begin
          cause_nxt = req_sel[NUM_SRC-1:0];
          state_nxt = ARMED;
        end
      end
      ARMED:    if (run_ok) state_nxt = DRAIN;
      DRAIN: begin
        // Timeout wins when both complete together so the flag is never lost.
        if (timeout_hit) begin
          dto_nxt   = 1'b1;
          state_nxt = WAIT_REC;
        end else if (idle_done) begin
          state_nxt = WAIT_REC;
        end
      end
      WAIT_REC: if (!bus.record_enable) state_nxt = GUARD;
      GUARD:    state_nxt = STOP;
      STOP:     state_nxt = STOP;
      default:  state_nxt = IDLE;
    endcase
`ifdef RVX_SIM_STOP_WATCHDOG_EN
    if (wd_hit && (state_q != STOP)) begin
      state_nxt    = STOP;
      cause_nxt    = '0;
      wd_fired_nxt = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      cause_q   <= '0;
      dto_q     <= 1'b0;
      run_cnt_q <= '0;
      to_cnt_q  <= '0;
    end else begin
      pending_q <= pending_q | bus.stop_req;
      cause_q   <= cause_nxt;
      dto_q     <= dto_nxt;
      if (!run_ok)
        run_cnt_q <= run_cnt_q + 1'b1;
      if (state_q != DRAIN)
        to_cnt_q <= '0;
      else if (to_cnt_q != TO_MAX)
        to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  assign bus.sim_stop      = (state_q == STOP);
  assign bus.stop_cause    = cause_q;
  assign bus.drain_timeout = dto_q;
  assign bus.seq_state     = state_q;

endmodule

// File: tb/tb_sim_stop_sequencer.sv
// Directed bench for sim_stop_sequencer: arbitration, latency, drain timeout,
// recording wait, reset recovery, and the watchdog when RVX_SIM_STOP_WATCHDOG_EN is set.
module tb_sim_stop_sequencer;
  import sim_stop_pkg::*;

  localparam int NUM_SRC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  sim_stop_sequencer_if #(.NUM_SRC(NUM_SRC)) bus ();

  sim_stop_sequencer #(
    .NUM_SRC         (NUM_SRC),
    .MIN_RUN_CYCLES  (1000),
    .BIT_CYCLES      (16),
    .DRAIN_BITS      (20),
    .DRAIN_TIMEOUT   (5000)
`ifdef RVX_SIM_STOP_WATCHDOG_EN
    ,
    .WATCHDOG_CYCLES (20000)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Cycle index since the last reset edge; equals the number of run cycles elapsed.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic toggle_to(input int target);
    while (cyc < target) begin
      bus.uart_tx = (cyc % 100 == 0) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.stop_req = '0;
    bus.uart_tx = 1'b1;
    bus.record_enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.stop_req = '0;
    bus.uart_tx = 1'b1;
    bus.record_enable = 1'b0;

    // Pulse on source 2 before run time elapses.
    do_reset();
    check("rst_sim_stop", 32'(bus.sim_stop), 0);
    check("rst_cause", 32'(bus.stop_cause), 0);
    check("rst_dto", 32'(bus.drain_timeout), 0);
    check("rst_state", 32'(bus.seq_state), 0);
    wait_cyc(50);
    bus.stop_req = 4'b0100;
    @(negedge clk);
    bus.stop_req = '0;
    @(negedge clk);
    check("t1_armed", 32'(bus.seq_state), 1);
    check("t1_cause", 32'(bus.stop_cause), 32'h4);
    wait_cyc(1000);
    check("t1_still_armed", 32'(bus.seq_state), 1);
    @(negedge clk);
    check("t1_drain_entry", 32'(bus.seq_state), 2);
    wait_cyc(1320);
    check("t1_drain_last", 32'(bus.seq_state), 2);
    @(negedge clk);
    check("t1_wait_rec", 32'(bus.seq_state), 3);
    @(negedge clk);
    check("t1_guard", 32'(bus.seq_state), 4);
    check("t1_stop_low", 32'(bus.sim_stop), 0);
    @(negedge clk);
    check("t1_stop_high", 32'(bus.sim_stop), 1);
    check("t1_stop_state", 32'(bus.seq_state), 5);
    check("t1_dto", 32'(bus.drain_timeout), 0);
    bus.stop_req = 4'b0001;
    @(negedge clk);
    bus.stop_req = '0;
    wait_cyc(1340);
    check("t1_cause_frozen", 32'(bus.stop_cause), 32'h4);
    check("t1_sticky", 32'(bus.sim_stop), 1);

    // Simultaneous sources after run time: lowest index wins, N+4 latency.
    do_reset();
    wait_cyc(2000);
    bus.stop_req = 4'b0110;
    @(negedge clk);
    @(negedge clk);
    check("t2_armed", 32'(bus.seq_state), 1);
    check("t2_cause", 32'(bus.stop_cause), 32'h2);
    wait_cyc(2324);
    check("t2_stop_low", 32'(bus.sim_stop), 0);
    @(negedge clk);
    check("t2_stop_high", 32'(bus.sim_stop), 1);
    bus.stop_req = '0;

    // Drain never completes: exit by timeout, then recording holds WAIT_REC.
    do_reset();
    bus.record_enable = 1'b1;
    bus.stop_req = 4'b0001;
    @(negedge clk);
    bus.stop_req = '0;
    toggle_to(1001);
    check("t3_drain_entry", 32'(bus.seq_state), 2);
    toggle_to(6000);
    check("t3_drain_before_to", 32'(bus.seq_state), 2);
    check("t3_dto_low", 32'(bus.drain_timeout), 0);
    toggle_to(6001);
    check("t3_wait_rec", 32'(bus.seq_state), 3);
    check("t3_dto_high", 32'(bus.drain_timeout), 1);
    bus.uart_tx = 1'b1;
    wait_cyc(6701);
    check("t4_held", 32'(bus.seq_state), 3);
    check("t4_no_stop", 32'(bus.sim_stop), 0);
    bus.record_enable = 1'b0;
    @(negedge clk);
    check("t4_guard_no_stop", 32'(bus.sim_stop), 0);
    @(negedge clk);
    check("t4_stop_2cyc", 32'(bus.sim_stop), 1);
    check("t4_dto_sticky", 32'(bus.drain_timeout), 1);
    check("t4_cause", 32'(bus.stop_cause), 32'h1);

    // uart_tx low on the completing cycle restarts the idle count.
    do_reset();
    bus.record_enable = 1'b1;
    bus.stop_req = 4'b0001;
    @(negedge clk);
    bus.stop_req = '0;
    wait_cyc(1320);
    bus.uart_tx = 1'b0;
    @(negedge clk);
    bus.uart_tx = 1'b1;
    check("t5_restart_drain", 32'(bus.seq_state), 2);
    wait_cyc(1640);
    check("t5_drain_last", 32'(bus.seq_state), 2);
    @(negedge clk);
    check("t5_wait_rec", 32'(bus.seq_state), 3);
    wait_cyc(1645);

    // Reset while in WAIT_REC, with a request coinciding with reset.
    @(negedge clk);
    rst = 1'b1;
    bus.stop_req = 4'b0001;
    bus.record_enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bus.stop_req = '0;
    check("t6_state", 32'(bus.seq_state), 0);
    check("t6_sim_stop", 32'(bus.sim_stop), 0);
    check("t6_cause", 32'(bus.stop_cause), 0);
    check("t6_dto", 32'(bus.drain_timeout), 0);
    wait_cyc(3);
    check("t6_req_in_rst_ignored", 32'(bus.seq_state), 0);
    wait_cyc(10);
    bus.stop_req = 4'b1000;
    @(negedge clk);
    bus.stop_req = '0;
    @(negedge clk);
    check("t6_armed", 32'(bus.seq_state), 1);
    check("t6_cause", 32'(bus.stop_cause), 32'h8);
    wait_cyc(1000);
    check("t6_fresh_run", 32'(bus.seq_state), 1);
    @(negedge clk);
    check("t6_drain", 32'(bus.seq_state), 2);

`ifdef RVX_SIM_STOP_WATCHDOG_EN
    do_reset();
    check("wd_rst", 32'(bus.watchdog_fired), 0);
    wait_cyc(20000);
    check("wd_not_yet", 32'(bus.watchdog_fired), 0);
    check("wd_idle", 32'(bus.seq_state), 0);
    @(negedge clk);
    check("wd_fired", 32'(bus.watchdog_fired), 1);
    check("wd_sim_stop", 32'(bus.sim_stop), 1);
    check("wd_cause", 32'(bus.stop_cause), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
